// File: rtl/accumulate_pkg.sv
`default_nettype none
// ============================================================================
// Package  : accumulate_pkg
// Brief    : Shared constants and sequencer state encoding for the accumulate
//            kernel host and its kernel wrapper.
// Revision : 1.0 - initial release
// ============================================================================
package accumulate_pkg;

    localparam int ACC_DEPTH   = 1000;
    localparam int ACC_AW      = 10;
    localparam int ACC_DW      = 64;
    localparam int ACC_TIMEOUT = 8192;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        KICK  = 3'd2,
        RUN   = 3'd3,
        DRAIN = 3'd4,
        FIN   = 3'd5
    } state_t;

endpackage
`default_nettype wire

// File: rtl/accumulate_rd_skid.sv
`default_nettype none
// ============================================================================
// Module   : accumulate_rd_skid
// Brief    : Two-entry output buffer absorbing the one-cycle kernel read latency.
// Revision : 1.0 - initial release
// ============================================================================
module accumulate_rd_skid #(
    parameter int DW = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_push,
    input  logic          i_push_last,
    input  logic [DW-1:0] i_push_data,
    input  logic          i_ready,
    output logic          o_valid,
    output logic [DW-1:0] o_data,
    output logic          o_last,
    output logic [1:0]    o_count
);

    logic [DW:0] r_mem [2];
    logic        r_wr_ptr;
    logic        r_rd_ptr;
    logic [1:0]  r_count;
    logic        w_pop;

    assign w_pop = o_valid && i_ready;

    // Storage carries no reset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= {i_push_last, i_push_data};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({i_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_valid = (r_count != 2'd0);
    assign o_data  = r_mem[r_rd_ptr][DW-1:0];
    assign o_last  = o_valid && r_mem[r_rd_ptr][DW];
    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/accumulate_host.sv
`default_nettype none
// ============================================================================
// Module   : accumulate_host
// Brief    : Loads a stream into the accumulate kernel array, runs the kernel
//            under a watchdog and streams the prefix-summed array back out.
// Revision : 1.0 - initial release
// ============================================================================
module accumulate_host
    import accumulate_pkg::*;
#(
    parameter int DEPTH   = ACC_DEPTH,
    parameter int AW      = ACC_AW,
    parameter int DW      = ACC_DW,
    parameter int TIMEOUT = ACC_TIMEOUT
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW:0]   cfg_len,
    input  logic [DW-1:0] cfg_init_acc,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic          result_bit,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    output logic          k_r_enable,
    input  logic          k_w_enable,
    input  logic          k_result,
    output logic          k_controlArr,
    output logic [AW-1:0] k_init_i,
    output logic [DW-1:0] k_init_acc,
    output logic          k_we,
    output logic [AW-1:0] k_addr,
    output logic [DW-1:0] k_wdata,
    input  logic [DW-1:0] k_rdata
);

    localparam int          c_wdog_w   = $clog2(TIMEOUT);
    localparam logic [AW-1:0] c_depth_aw = AW'(DEPTH);
    localparam logic [AW:0] c_one      = (AW+1)'(1);

    state_t              r_state;
    state_t              w_next;
    logic [AW:0]         r_len;
    logic [AW:0]         r_cnt;
    logic [AW:0]         r_rcnt;
    logic [AW-1:0]       r_base;
    logic [DW-1:0]       r_init_acc;
    logic [c_wdog_w-1:0] r_wdog;
    logic                r_first_run;
    logic                r_err;
    logic                r_result;
    logic                r_rd_pend;
    logic                r_rd_pend_last;
    logic                w_load_hs;
    logic                w_pop;
    logic                w_room;
    logic                w_rd_issue;
    logic                w_rd_last;
    logic                w_wen_seen;
    logic                w_timeout;
    logic [1:0]          w_skid_count;

    assign w_load_hs  = (r_state == LOAD) && in_valid;
    assign w_pop      = out_valid && out_ready;
    // A read may be issued when the buffer, counting the read still in flight,
    // keeps a free slot; a same-cycle pop frees one.
    assign w_room     = ({1'b0, w_skid_count} + {2'b00, r_rd_pend}) < (3'd2 + {2'b00, w_pop});
    assign w_rd_issue = (r_state == DRAIN) && (r_rcnt < r_len) && w_room;
    assign w_rd_last  = (r_rcnt == r_len - c_one);
    assign w_wen_seen = (r_state == RUN) && !r_first_run && k_w_enable;
    assign w_timeout  = (r_state == RUN) && (r_wdog == c_wdog_w'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (start) w_next = (cfg_len == '0) ? KICK : LOAD;
            LOAD:    if (w_load_hs && (r_cnt == r_len - c_one)) w_next = KICK;
            KICK:    w_next = RUN;
            RUN: begin
                if (w_wen_seen) begin
                    w_next = (r_len == '0) ? FIN : DRAIN;
                end else if (w_timeout) begin
                    w_next = FIN;
                end
            end
            DRAIN:   if (w_pop && out_last) w_next = FIN;
            FIN:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        busy         = (r_state != IDLE);
        done         = (r_state == FIN);
        in_ready     = (r_state == LOAD);
        k_r_enable   = (r_state != RUN);
        k_controlArr = (r_state != RUN);
        k_we         = w_load_hs;
        k_addr       = r_base;
        case (r_state)
            LOAD:    k_addr = r_base + r_cnt[AW-1:0];
            DRAIN:   k_addr = r_base + r_rcnt[AW-1:0];
            default: k_addr = r_base;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_len          <= '0;
            r_base         <= '0;
            r_init_acc     <= '0;
            r_cnt          <= '0;
            r_rcnt         <= '0;
            r_wdog         <= '0;
            r_first_run    <= 1'b0;
            r_err          <= 1'b0;
            r_result       <= 1'b0;
            r_rd_pend      <= 1'b0;
            r_rd_pend_last <= 1'b0;
        end else begin
            if ((r_state == IDLE) && start) begin
                r_len      <= cfg_len;
                r_base     <= c_depth_aw - cfg_len[AW-1:0];
                r_init_acc <= cfg_init_acc;
                r_err      <= 1'b0;
                r_cnt      <= '0;
                r_rcnt     <= '0;
            end
            if (w_load_hs) begin
                r_cnt <= r_cnt + c_one;
            end
            // The kernel's w_enable is still high from the previous run during
            // the first RUN cycle, so that cycle is masked.
            r_first_run <= (r_state == KICK);
            r_wdog      <= (r_state == RUN) ? r_wdog + c_wdog_w'(1) : '0;
            if (w_wen_seen) begin
                r_result <= k_result;
            end else if (w_timeout) begin
                r_err <= 1'b1;
            end
            if (w_rd_issue) begin
                r_rcnt <= r_rcnt + c_one;
            end
            r_rd_pend      <= w_rd_issue;
            r_rd_pend_last <= w_rd_issue && w_rd_last;
        end
    end

    accumulate_rd_skid #(
        .DW (DW)
    ) u_skid (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (r_rd_pend),
        .i_push_last (r_rd_pend_last),
        .i_push_data (k_rdata),
        .i_ready     (out_ready),
        .o_valid     (out_valid),
        .o_data      (out_data),
        .o_last      (out_last),
        .o_count     (w_skid_count)
    );

    assign err        = r_err;
    assign result_bit = r_result;
    assign k_init_i   = r_base;
    assign k_init_acc = r_init_acc;
    assign k_wdata    = in_data;

endmodule
`default_nettype wire

// File: tb/tb_accumulate_host.sv
`default_nettype none
// ============================================================================
// Module   : tb_accumulate_host
// Brief    : Self-checking bench: behavioural kernel plus a prefix-sum stream
//            model compared against the host on every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_accumulate_host;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [10:0] cfg_len = '0;
    logic [63:0] cfg_init_acc = '0;
    logic        busy, done, err, result_bit;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_data;
    logic        out_last;
    logic        k_r_enable;
    logic        k_w_enable = 1'b0;
    logic        k_result = 1'b0;
    logic        k_controlArr;
    logic [9:0]  k_init_i;
    logic [63:0] k_init_acc;
    logic        k_we;
    logic [9:0]  k_addr;
    logic [63:0] k_wdata;
    logic [63:0] k_rdata = '0;

    always #5 clk = ~clk;

    accumulate_host #(
        .TIMEOUT (64)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .cfg_len      (cfg_len),
        .cfg_init_acc (cfg_init_acc),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .result_bit   (result_bit),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_last     (out_last),
        .k_r_enable   (k_r_enable),
        .k_w_enable   (k_w_enable),
        .k_result     (k_result),
        .k_controlArr (k_controlArr),
        .k_init_i     (k_init_i),
        .k_init_acc   (k_init_acc),
        .k_we         (k_we),
        .k_addr       (k_addr),
        .k_wdata      (k_wdata),
        .k_rdata      (k_rdata)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Kernel stand-in: host port active while controlArr=1; one prefix-sum
    // pass on the first released cycle, w_enable after k_lat more cycles and
    // left high (stale) until the next release.
    logic [63:0] kmem [0:999];
    logic [9:0]  k_i0;
    logic [63:0] k_a0;
    logic [63:0] k_sum;
    bit          k_started = 0;
    bit          k_stuck = 0;
    int          k_lat = 0;
    int          k_cnt = 0;

    always @(posedge clk) begin
        logic [63:0] acc;
        if (k_controlArr) begin
            if (k_we) begin
                if (k_addr < 10'd1000) kmem[k_addr] = k_wdata;
            end else if (k_addr < 10'd1000) begin
                k_rdata <= kmem[k_addr];
            end
        end
        if (k_r_enable) begin
            k_i0      = k_init_i;
            k_a0      = k_init_acc;
            k_started = 0;
        end else if (!k_started) begin
            k_started = 1;
            k_w_enable <= 1'b0;
            k_cnt = k_lat;
            acc = k_a0;
            for (int i = int'(k_i0); i < 1000; i++) begin
                acc = acc + kmem[i];
                kmem[i] = acc;
            end
            k_sum = acc;
        end else if (k_cnt > 0) begin
            k_cnt--;
        end else if (!k_stuck) begin
            k_w_enable <= 1'b1;
            k_result   <= k_sum[0];
        end
    end

    // Reference model state, written by the driver, consumed by the monitor.
    logic [63:0] job_data[$];
    logic [63:0] exp_q[$];
    logic [63:0] obs_q[$];
    int          exp_n = 0;
    int          exp_base = 0;
    logic [63:0] exp_init = '0;
    logic        exp_result = 1'b0;
    int          load_idx = 0;
    int          first_addr = -1;
    int          done_seen = 0;
    int          run_cycles = 0;
    int          rmode = 0;
    bit          mon_en = 0;
    logic        pv = 1'b0;
    logic        pr = 1'b0;
    logic [63:0] pdata = '0;

    always @(negedge clk) begin
        logic [63:0] e;
        if (mon_en && rst_n) begin
            if (!busy) chk("idle_r_enable", k_r_enable, 1);
            if (!k_r_enable) begin
                run_cycles++;
                chk("run_controlArr", k_controlArr, 0);
                chk("run_we", k_we, 0);
            end
            if (busy) begin
                chk("init_i", k_init_i, exp_base);
                chk("init_acc", k_init_acc, exp_init);
            end
            if (in_ready && load_idx >= exp_n) chk("in_ready_after_n", in_ready, 0);
            if (in_valid && in_ready && load_idx < exp_n) begin
                chk("load_we", k_we, 1);
                chk("load_addr", k_addr, (exp_base + load_idx) % 1024);
                if (load_idx == 0) first_addr = int'(k_addr);
                load_idx++;
            end
            if (pv && !pr) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_data", out_data, pdata);
            end
            if (exp_q.size() == 0) begin
                chk("spurious_valid", out_valid, 0);
            end else if (out_valid && out_ready) begin
                e = exp_q.pop_front();
                chk("out_data", out_data, e);
                chk("out_last", out_last, exp_q.size() == 0);
                obs_q.push_back(out_data);
            end
            if (done) done_seen++;
            pv = out_valid;
            pr = out_ready;
            pdata = out_data;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rmode)
                0:       out_ready = 1'b1;
                1:       out_ready = ~out_ready;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic do_start(input int n, input logic [63:0] init, input bit stuck, input int lat);
        logic [63:0] acc;
        int g = 0;
        while (busy && g < 5000) begin
            @(posedge clk); #1; g++;
        end
        k_stuck = stuck;
        k_lat = lat;
        exp_q.delete();
        obs_q.delete();
        acc = init;
        foreach (job_data[i]) begin
            acc = acc + job_data[i];
            if (!stuck) exp_q.push_back(acc);
        end
        if (!stuck) exp_result = acc[0];
        exp_n = n;
        exp_base = (1000 - n) & 1023;
        exp_init = init;
        load_idx = 0;
        first_addr = -1;
        done_seen = 0;
        run_cycles = 0;
        start = 1'b1;
        cfg_len = 11'(n);
        cfg_init_acc = init;
        @(posedge clk); #1;
        start = 1'b0;
        cfg_len = 11'($urandom);
        cfg_init_acc = {$urandom, $urandom};
        chk("err_cleared", err, 0);
        chk("busy_after_start", busy, 1);
    endtask

    task automatic feed(input int n, input bit vrand, input bit glitch);
        int sent = 0;
        int g = 0;
        bit hs;
        while (sent < n && g < 20000) begin
            in_valid = vrand ? ($urandom_range(0, 3) != 0) : 1'b1;
            in_data = job_data[sent];
            if (glitch && sent == 1) begin
                start = 1'b1;
                cfg_len = 11'd3;
                cfg_init_acc = 64'hdead;
            end
            hs = in_valid && in_ready;
            @(posedge clk); #1;
            start = 1'b0;
            if (hs) sent++;
            g++;
        end
        in_valid = 1'b0;
        chk("load_complete", sent, n);
    endtask

    task automatic finish_job(input int n, input bit stuck, input int lat);
        int g = 0;
        while (done_seen == 0 && g < 8000) begin
            @(posedge clk); #1; g++;
        end
        @(posedge clk); #1;
        chk("done_pulses", done_seen, 1);
        chk("leftover_beats", exp_q.size(), 0);
        chk("err", err, stuck);
        chk("result_bit", result_bit, exp_result);
        chk("loaded", load_idx, n);
        chk("run_cycles", run_cycles, stuck ? 64 : lat + 3);
        chk("busy_end", busy, 0);
    endtask

    task automatic run_job(input int n, input logic [63:0] init, input int rm, input bit vrand,
                           input bit stuck, input int lat, input bit glitch);
        rmode = rm;
        do_start(n, init, stuck, lat);
        feed(n, vrand, glitch);
        finish_job(n, stuck, lat);
    endtask

    initial begin
        int n;
        int g;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_result", result_bit, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_r_enable", k_r_enable, 1);
        chk("rst_controlArr", k_controlArr, 1);
        chk("rst_we", k_we, 0);
        rst_n = 1'b1;
        mon_en = 1;
        @(posedge clk); #1;

        job_data = '{64'd1, 64'd2, 64'd3};
        run_job(3, 64'd10, 0, 0, 0, 2, 0);
        chk("pin_n3_beats", obs_q.size(), 3);
        if (obs_q.size() == 3) begin
            chk("pin_n3_b0", obs_q[0], 64'd11);
            chk("pin_n3_b1", obs_q[1], 64'd13);
            chk("pin_n3_b2", obs_q[2], 64'd16);
        end
        chk("pin_n3_addr", first_addr, 997);
        chk("pin_n3_result", result_bit, 0);

        job_data.delete();
        run_job(0, 64'd5, 0, 0, 0, 1, 0);
        chk("pin_n0_beats", obs_q.size(), 0);

        job_data = '{64'd1, 64'd1, 64'd1, 64'd1};
        run_job(4, 64'd1, 1, 0, 0, 0, 0);
        chk("pin_n4_beats", obs_q.size(), 4);
        if (obs_q.size() == 4) begin
            chk("pin_n4_b0", obs_q[0], 64'd2);
            chk("pin_n4_b3", obs_q[3], 64'd5);
        end

        job_data = '{64'd4, 64'd5, 64'd6, 64'd7, 64'd8};
        run_job(5, 64'd0, 2, 1, 1, 0, 0);
        chk("pin_timeout_err", err, 1);
        job_data = '{64'd3, 64'd9};
        run_job(2, 64'd100, 2, 1, 0, 3, 0);

        // Abort part-way through the read-back.
        job_data.delete();
        for (int i = 0; i < 20; i++) job_data.push_back({$urandom, $urandom});
        rmode = 2;
        do_start(20, {$urandom, $urandom}, 0, 1);
        feed(20, 1, 0);
        g = 0;
        while (obs_q.size() < 3 && g < 3000) begin
            @(posedge clk); #1; g++;
        end
        chk("reached_drain", obs_q.size() >= 3, 1);
        mon_en = 0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("abort_busy", busy, 0);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_r_enable", k_r_enable, 1);
        chk("abort_err", err, 0);
        chk("abort_result", result_bit, 0);
        exp_q.delete();
        exp_n = 0;
        exp_result = 1'b0;
        pv = 1'b0;
        mon_en = 1;
        job_data = '{64'd7, 64'd8};
        run_job(2, 64'd0, 0, 0, 0, 0, 0);
        chk("pin_abort_beats", obs_q.size(), 2);
        if (obs_q.size() == 2) begin
            chk("pin_abort_b0", obs_q[0], 64'd7);
            chk("pin_abort_b1", obs_q[1], 64'd15);
        end

        job_data.delete();
        for (int i = 0; i < 6; i++) job_data.push_back(64'(i * 3 + 1));
        run_job(6, 64'd50, 2, 1, 0, 2, 1);

        for (int j = 0; j < 12; j++) begin
            if (j == 3 || j == 8) n = 1000;
            else if (j == 5) n = 1;
            else n = $urandom_range(0, 40);
            job_data.delete();
            for (int i = 0; i < n; i++) job_data.push_back({$urandom, $urandom});
            run_job(n, {$urandom, $urandom}, $urandom_range(0, 2), 1'($urandom_range(0, 1)),
                    0, $urandom_range(0, 5), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/accumulate_host.md
Name: accumulate_host

Overview:
- Host-side sequencer directly upstream/downstream of the synthesized `main` accumulate kernel. It owns the kernel's `controlArr` port and its start/done pins.
- Loads a stream of 64-bit elements into the top of the kernel array, releases the kernel, and waits for completion.
- Then reads the prefix-summed array back as an output stream.
- Sits between the system's valid/ready stream fabric and the kernel instance.

Parameters:
- DEPTH, 1000, kernel array depth; must match the kernel's loop bound.
- AW, 10, array address width.
- DW, 64, element width.
- TIMEOUT, 8192, maximum RUN cycles before an error abort.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  one-cycle pulse, accepted only in IDLE.
- cfg_len  in  AW+1  element count N, 0..DEPTH, sampled on start.
- cfg_init_acc  in  DW  initial accumulator, sampled on start.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse on return to IDLE.
- err  out  1  sticky timeout flag; cleared by the next accepted start.
- result_bit  out  1  kernel `result` captured at completion.
- in_valid  in  1  input stream valid.
- in_ready  out  1  input stream ready.
- in_data  in  DW  input element.
- out_valid  out  1  output stream valid.
- out_ready  in  1  output stream ready.
- out_data  out  DW  read-back element.
- out_last  out  1  marks the final read-back element.
- k_r_enable  out  1  to kernel `r_enable`.
- k_w_enable  in  1  from kernel `w_enable`.
- k_result  in  1  from kernel `result`.
- k_controlArr  out  1  to kernel `controlArr`.
- k_init_i  out  AW  to kernel `init_i`.
- k_init_acc  out  DW  to kernel `init_acc`.
- k_we  out  1  to kernel `controlArrWEnable_a`.
- k_addr  out  AW  to kernel `controlArrAddr_a`.
- k_wdata  out  DW  to kernel `controlArrWData_a`.
- k_rdata  in  DW  from kernel `controlArrRData_a`; valid exactly 1 cycle after a non-write address.

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE. Outputs: busy=0, done=0, err=0, result_bit=0, in_ready=0, out_valid=0, out_last=0, k_r_enable=1, k_controlArr=1, k_we=0. The output buffer is emptied.
- base = DEPTH - N. k_init_i = base and k_init_acc = cfg_init_acc are held constant from start until IDLE.
- k_r_enable=1 in every state except RUN. This keeps the kernel parked in its initial state and reloads init values.
- k_controlArr=1 in every state except RUN. In RUN it is 0.
- IDLE:
  - start=1 latches the configuration and clears err.
  - N>0 goes to LOAD; N=0 goes to KICK.
  - start outside IDLE is ignored.
- LOAD:
  - in_ready=1.
  - On each handshake: k_we=1, k_addr=base+cnt, k_wdata=in_data, cnt++.
  - After the N-th handshake, go to KICK. No input is accepted afterwards.
- KICK: one cycle with k_r_enable=1 and k_controlArr=1, so init values are latched. Then go to RUN.
- RUN:
  - k_r_enable=0 and k_controlArr=0; the watchdog counts cycles.
  - When k_w_enable=1 is sampled: result_bit<=k_result, then go to DRAIN, or to FIN if N=0.
  - Watchdog reaching TIMEOUT: err<=1, go to FIN.
  - k_w_enable sampled in the first RUN cycle is stale from the previous run and is ignored.
- DRAIN:
  - Issue read address base+rcnt only when the 2-entry output buffer has room, counting the in-flight read.
  - Capture k_rdata one cycle later into the buffer.
  - out_last accompanies the element read from address DEPTH-1.
  - Go to FIN after the last element's handshake.
  - out_valid must not drop without a handshake. out_data must stay stable while out_valid=1 and out_ready=0.
  - With out_ready held at 1, throughput is 1 element/cycle after a 1-cycle startup.
- FIN: done=1 for one cycle, then go to IDLE.
- Address arithmetic is modulo 2^AW. N=DEPTH gives base=0.
- Reset asserted mid-operation aborts immediately to the reset values. Array contents are undefined afterwards.

Decomposition:
- Shared package accumulate_pkg: state enum (IDLE, LOAD, KICK, RUN, DRAIN, FIN) plus the DEPTH/AW/DW constants shared with the kernel wrapper.
- One natural sub-module: accumulate_rd_skid, the 2-entry output buffer that absorbs the 1-cycle read latency.

Test Plan:
- N=3, init_acc=10, input 1,2,3 → writes to addrs 997,998,999; output 11,13,16 with out_last on 16; result_bit=0; done pulses once.
- N=0, init_acc=5 → no in_ready, kernel runs, no output beats, done pulses; kernel loop terminates immediately.
- N=4, input 1,1,1,1, out_ready toggling 1/0 every cycle → outputs 2,3,4,5 in order, no drops or duplicates, out_data stable while stalled.
- Kernel model that never raises w_enable, TIMEOUT=64 → err=1 after 64 RUN cycles, done pulses, no output; the next start clears err.
- rst_n low for one cycle mid-DRAIN → next cycle busy=0, out_valid=0, k_r_enable=1; a fresh N=2 run with input 7,8 and init_acc=0 produces 7,15.
- start pulsed during LOAD → ignored; the configuration latched at the original start is unchanged.
